trace_byte_streamer: RTL and testbench
======================================

// Module: trace_byte_streamer
// PURPOSE
//  Consumes the serialized single-port retire trace (debug_wb_*) and exports it
//  as a framed byte stream for an off-chip link (UART/JTAG bridge).
//  Records are buffered in a small FIFO because the trace source cannot stall.
//  Each record becomes one 11-byte frame: sync, PC, register number, data, checksum.
//  The byte link uses a valid/ready handshake.
// PARAMETERS
//  FIFO_DEPTH  16     record FIFO depth; must be a power of 2
//  FIFO_AW     4      log2(FIFO_DEPTH)
//  SYNC_BYTE   8'hA5  first byte of every frame
// PORTS
//  clk                in   1          single clock
//  reset              in   1          asynchronous, active-high reset
//  debug_wb_rf_wen    in   4          record valid when any bit is set
//  debug_wb_pc        in   32         retired PC
//  debug_wb_rf_wnum   in   5          destination register number
//  debug_wb_rf_wdata  in   32         write-back data
//  tx_data            out  8          current output byte
//  tx_valid           out  1          tx_data is valid
//  tx_ready           in   1          sink accepts the byte on clk when tx_valid is high
//  overflow           out  1          sticky: at least one record was dropped
//  drop_count         out  16         dropped-record count, saturates at 16'hFFFF
//  fifo_level         out  FIFO_AW+1  records currently held in the FIFO (excludes the frame in flight)
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - All outputs go to 0; the FSM goes to IDLE.
//   - FIFO pointers are cleared and its contents discarded.
//   - A frame in progress is abandoned; no partial frame is completed after release.
//  Capture
//   - Sampled every cycle; a record is present when |debug_wb_rf_wen.
//   - Push {pc, wnum, wdata} if the pre-edge level < FIFO_DEPTH.
//   - Otherwise drop the record: overflow <= 1 and drop_count++ (saturating).
//   - Full is judged on the pre-edge level. A push at level==DEPTH is dropped
//     even if a pop happens in the same cycle.
//   - Simultaneous push and pop below full: level is unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
//  Frame (bytes in order, MSB first)
//   - SYNC_BYTE
//   - PC[31:24], PC[23:16], PC[15:8], PC[7:0]
//   - {3'b0, wnum}
//   - D[31:24], D[23:16], D[15:8], D[7:0]
//   - CSUM = XOR of the 9 payload bytes; the sync byte is excluded.
//  FSM states: IDLE, SYNC, PC (byte index 0..3), NUM, DATA (byte index 0..3), CSUM
//   - IDLE: tx_valid=0. If the FIFO is non-empty, pop the head into a holding
//     register and go to SYNC, with tx_valid=1 and tx_data=SYNC_BYTE registered.
//   - Other states: advance one byte only on the edge where tx_valid&&tx_ready.
//     tx_data and tx_valid stay stable while tx_ready=0.
//   - CSUM accepted with FIFO non-empty: pop and go directly to SYNC (no bubble).
//   - CSUM accepted with FIFO empty: go to IDLE, tx_valid=0.
//   - The checksum is accumulated as bytes are issued or precomputed from the
//     holding register; either way CSUM is valid in the cycle it is presented.
//  Latency: record on the inputs in cycle C gives tx_valid=1 with SYNC_BYTE in
//   cycle C+2 when the FSM is IDLE. Frame throughput is 11 cycles with tx_ready
//   held high.
//  Capacity: FIFO_DEPTH records in the FIFO plus 1 in the holding register.
// TESTING
//  1 Single record pc=32'hBFC00000, wnum=5, wdata=32'h12345678, tx_ready=1
//    -> A5 BF C0 00 00 05 12 34 56 78 72, first byte in cycle C+2.
//  2 Same record with tx_ready=0 for 5 cycles while byte PC[23:16] is presented
//    -> tx_data stays 8'hC0 with tx_valid=1; the rest of the frame is unchanged.
//  3 Two records in consecutive cycles, tx_ready=1 -> 22 contiguous bytes, no
//    idle cycle between the frames.
//  4 tx_ready=0, 20 records on consecutive cycles, FIFO_DEPTH=16 -> fifo_level=16,
//    overflow=1, drop_count=3. Release tx_ready -> 17 correct frames.
//  5 Assert reset after 4 bytes of a frame are accepted -> tx_valid=0 immediately.
//    After release: fifo_level=0, no further bytes, overflow=0.
//  6 debug_wb_rf_wen=4'h0 with arbitrary pc/data for 50 cycles -> no push,
//    tx_valid stays 0.

Source files
------------

// File: rtl/trace_byte_streamer.sv
// Buffers single-port retire trace records in a small FIFO and emits each one
// as an 11-byte frame (sync, PC, regnum, data, XOR checksum) over valid/ready.
module trace_byte_streamer #(
  parameter int          FIFO_DEPTH = 16,
  parameter int          FIFO_AW    = 4,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         debug_wb_rf_wen,
  input  logic [31:0]        debug_wb_pc,
  input  logic [4:0]         debug_wb_rf_wnum,
  input  logic [31:0]        debug_wb_rf_wdata,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               overflow,
  output logic [15:0]        drop_count,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int REC_W = 69;
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_PC   = 3'd2,
    ST_NUM  = 3'd3,
    ST_DATA = 3'd4,
    ST_CSUM = 3'd5
  } state_t;

  // Record layout: {pc[68:37], wnum[36:32], wdata[31:0]}
  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
    logic [1:0] k;
    k = 2'd3 - idx;
    return word[{k, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] frame_csum(input logic [REC_W-1:0] rec);
    logic [7:0] c;
    c = {3'b000, rec[36:32]};
    for (int i = 0; i < 4; i++) begin
      c = c ^ rec[37 + 8*i +: 8] ^ rec[8*i +: 8];
    end
    return c;
  endfunction

  logic [REC_W-1:0] r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wptr, r_rptr;
  logic [FIFO_AW:0]   r_level;
  logic               r_overflow;
  logic [15:0]        r_drop_count;
  state_t             r_state;
  logic [1:0]         r_idx;
  logic [REC_W-1:0]   r_hold;
  logic [7:0]         r_tx_data;
  logic               r_tx_valid;

  logic               w_rec_valid, w_push, w_drop, w_pop, w_accept, w_nonempty;
  logic [REC_W-1:0]   w_head;
  state_t             w_next_state;
  logic [1:0]         w_next_idx;
  logic [7:0]         w_next_data;
  logic               w_next_valid;

  // Full/empty are judged on the pre-edge level so a pop never frees a slot early.
  assign w_rec_valid = |debug_wb_rf_wen;
  assign w_push      = w_rec_valid && (r_level < DEPTH_L);
  assign w_drop      = w_rec_valid && (r_level >= DEPTH_L);
  assign w_nonempty  = (r_level != '0);
  assign w_accept    = r_tx_valid && tx_ready;
  assign w_head      = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_level      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= 16'd0;
    end else begin
      if (w_push) r_wptr <= r_wptr + FIFO_AW'(1);
      if (w_pop)  r_rptr <= r_rptr + FIFO_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (FIFO_AW+1)'(1);
        2'b01:   r_level <= r_level - (FIFO_AW+1)'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= 2'd0;
      r_hold     <= '0;
      r_tx_data  <= 8'd0;
      r_tx_valid <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_idx      <= w_next_idx;
      r_tx_data  <= w_next_data;
      r_tx_valid <= w_next_valid;
      if (w_pop) r_hold <= w_head;
    end
  end

  // Next byte is prepared one edge ahead so tx_data/tx_valid come straight from flops.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_next_data  = r_tx_data;
    w_next_valid = r_tx_valid;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_nonempty) begin
          w_pop        = 1'b1;
          w_next_state = ST_SYNC;
          w_next_valid = 1'b1;
          w_next_data  = SYNC_BYTE;
        end else begin
          w_next_valid = 1'b0;
        end
      end
      ST_SYNC: begin
        if (w_accept) begin
          w_next_state = ST_PC;
          w_next_idx   = 2'd0;
          w_next_data  = byte_of(r_hold[68:37], 2'd0);
        end else begin
          w_next_state = ST_SYNC;
        end
      end
      ST_PC: begin
        if (w_accept && (r_idx == 2'd3)) begin
          w_next_state = ST_NUM;
          w_next_data  = {3'b000, r_hold[36:32]};
        end else if (w_accept) begin
          w_next_idx  = r_idx + 2'd1;
          w_next_data = byte_of(r_hold[68:37], r_idx + 2'd1);
        end else begin
          w_next_state = ST_PC;
        end
      end
      ST_NUM: begin
        if (w_accept) begin
          w_next_state = ST_DATA;
          w_next_idx   = 2'd0;
          w_next_data  = byte_of(r_hold[31:0], 2'd0);
        end else begin
          w_next_state = ST_NUM;
        end
      end
      ST_DATA: begin
        if (w_accept && (r_idx == 2'd3)) begin
          w_next_state = ST_CSUM;
          w_next_data  = frame_csum(r_hold);
        end else if (w_accept) begin
          w_next_idx  = r_idx + 2'd1;
          w_next_data = byte_of(r_hold[31:0], r_idx + 2'd1);
        end else begin
          w_next_state = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (w_accept && w_nonempty) begin
          w_pop        = 1'b1;
          w_next_state = ST_SYNC;
          w_next_data  = SYNC_BYTE;
        end else if (w_accept) begin
          w_next_state = ST_IDLE;
          w_next_valid = 1'b0;
        end else begin
          w_next_state = ST_CSUM;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_valid = 1'b0;
      end
    endcase
  end

  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;
  assign fifo_level = r_level;

endmodule

// File: tb/tb_trace_byte_streamer.sv
// Randomized and directed bench for trace_byte_streamer; every accepted byte is
// compared against a frame list built from the records the bench injected.
module tb_trace_byte_streamer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  wen = 4'h0;
  logic [31:0] pc = 32'h0;
  logic [4:0]  wnum = 5'h0;
  logic [31:0] wdata = 32'h0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        overflow;
  logic [15:0] drop_count;
  logic [4:0]  fifo_level;

  int          n_checks = 0;
  int          n_fails = 0;
  logic [7:0]  exp_q[$];
  int          acc_cnt = 0;
  bit          rnd_done = 1'b0;

  always #5 clk = ~clk;

  trace_byte_streamer #(.FIFO_DEPTH(16), .FIFO_AW(4), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset),
    .debug_wb_rf_wen(wen), .debug_wb_pc(pc), .debug_wb_rf_wnum(wnum),
    .debug_wb_rf_wdata(wdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .overflow(overflow), .drop_count(drop_count), .fifo_level(fifo_level)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference frame: sync, PC bytes MSB first, {000,wnum}, data bytes, XOR of payload.
  task automatic add_frame(input logic [31:0] p, input logic [4:0] n, input logic [31:0] d);
    logic [7:0] b [11];
    logic [7:0] cs;
    b[0] = 8'hA5;
    for (int i = 0; i < 4; i++) b[1+i] = 8'((p >> (24 - 8*i)) % 256);
    b[5] = 8'(n);
    for (int i = 0; i < 4; i++) b[6+i] = 8'((d >> (24 - 8*i)) % 256);
    cs = 8'h00;
    for (int i = 1; i <= 9; i++) cs = cs ^ b[i];
    b[10] = cs;
    for (int i = 0; i < 11; i++) exp_q.push_back(b[i]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rec(input logic [31:0] p, input logic [4:0] n, input logic [31:0] d);
    wen   = 4'($urandom_range(1, 15));
    pc    = p;
    wnum  = n;
    wdata = d;
    step();
    wen   = 4'h0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !tx_valid) break;
      step();
    end
    check("drain_remaining", 32'(exp_q.size()), 32'd0);
    check("drain_idle", {31'd0, tx_valid}, 32'd0);
  endtask

  // Scoreboard: every byte the sink accepts must be the next expected byte.
  always @(negedge clk) begin
    if (!reset && tx_valid && tx_ready) begin
      acc_cnt++;
      check("byte_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) check("stream_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
    end
  end

  initial begin
    logic [31:0] rp, rd;
    logic [4:0]  rn;
    int          base;
    bit          found;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_drop_count", {16'd0, drop_count}, 32'd0);
    check("rst_fifo_level", {27'd0, fifo_level}, 32'd0);
    reset = 1'b0;
    step();

    // Test 1: golden frame and C+2 latency
    tx_ready = 1'b1;
    add_frame(32'hBFC00000, 5'd5, 32'h12345678);
    check("t1_golden_csum", {24'd0, exp_q[10]}, 32'h72);
    drive_rec(32'hBFC00000, 5'd5, 32'h12345678);
    @(negedge clk);
    check("t1_c1_valid", {31'd0, tx_valid}, 32'd0);
    @(negedge clk);
    check("t1_c2_valid", {31'd0, tx_valid}, 32'd1);
    check("t1_c2_sync", {24'd0, tx_data}, 32'hA5);
    wait_drain(40);

    // Test 2: stall on PC[23:16]
    step();
    add_frame(32'hBFC00000, 5'd5, 32'h12345678);
    drive_rec(32'hBFC00000, 5'd5, 32'h12345678);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tx_valid && tx_data == 8'hC0) begin found = 1'b1; break; end
      step();
    end
    check("t2_reached_c0", {31'd0, found}, 32'd1);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_hold_valid", {31'd0, tx_valid}, 32'd1);
      check("t2_hold_data", {24'd0, tx_data}, 32'hC0);
    end
    step();
    tx_ready = 1'b1;
    wait_drain(40);

    // Test 3: back-to-back frames with no bubble
    step();
    for (int r = 0; r < 2; r++) begin
      rp = $urandom; rn = 5'($urandom); rd = $urandom;
      add_frame(rp, rn, rd);
      drive_rec(rp, rn, rd);
    end
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_valid) begin found = 1'b1; break; end
    end
    check("t3_started", {31'd0, found}, 32'd1);
    for (int i = 1; i < 22; i++) begin
      @(negedge clk);
      check("t3_contiguous", {31'd0, tx_valid}, 32'd1);
    end
    @(negedge clk);
    check("t3_idle_after", {31'd0, tx_valid}, 32'd0);
    wait_drain(20);

    // Random bursts with random back-pressure, kept below capacity
    step();
    rnd_done = 1'b0;
    fork
      begin
        for (int b = 0; b < 5; b++) begin
          for (int i = 0; i < 200; i++) begin
            if (fifo_level <= 5'd8) break;
            step();
          end
          for (int r = 0; r < int'($urandom_range(1, 8)); r++) begin
            rp = $urandom; rn = 5'($urandom); rd = $urandom;
            add_frame(rp, rn, rd);
            drive_rec(rp, rn, rd);
          end
          repeat ($urandom_range(0, 30)) step();
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          step();
          tx_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    tx_ready = 1'b1;
    wait_drain(2000);
    check("rnd_no_overflow", {31'd0, overflow}, 32'd0);

    // Test 4: overflow with the sink stalled; DEPTH+1 records survive
    step();
    tx_ready = 1'b0;
    for (int r = 0; r < 20; r++) begin
      rp = $urandom; rn = 5'($urandom); rd = $urandom;
      if (r < DEPTH + 1) add_frame(rp, rn, rd);
      wen = 4'($urandom_range(1, 15)); pc = rp; wnum = rn; wdata = rd;
      step();
    end
    wen = 4'h0;
    step();
    check("t4_level", {27'd0, fifo_level}, 32'd16);
    check("t4_overflow", {31'd0, overflow}, 32'd1);
    check("t4_drop_count", {16'd0, drop_count}, 32'd3);
    check("t4_queued_bytes", 32'(exp_q.size()), 32'd187);
    tx_ready = 1'b1;
    wait_drain(17 * 11 + 40);

    // Test 5: reset mid-frame abandons it and clears the FIFO
    step();
    for (int r = 0; r < 2; r++) begin
      rp = $urandom; rn = 5'($urandom); rd = $urandom;
      add_frame(rp, rn, rd);
      drive_rec(rp, rn, rd);
    end
    base = acc_cnt;
    for (int i = 0; i < 30; i++) begin
      if (acc_cnt - base >= 4) break;
      step();
    end
    check("t5_four_accepted", 32'(acc_cnt - base), 32'd4);
    #3;
    reset = 1'b1;
    #1;
    check("t5_valid_async", {31'd0, tx_valid}, 32'd0);
    check("t5_level_async", {27'd0, fifo_level}, 32'd0);
    check("t5_overflow_async", {31'd0, overflow}, 32'd0);
    check("t5_drop_async", {16'd0, drop_count}, 32'd0);
    exp_q.delete();
    step();
    step();
    reset = 1'b0;
    base = acc_cnt;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("t5_no_bytes", {31'd0, tx_valid}, 32'd0);
    end
    check("t5_no_accepts", 32'(acc_cnt - base), 32'd0);
    check("t5_level", {27'd0, fifo_level}, 32'd0);
    check("t5_overflow", {31'd0, overflow}, 32'd0);

    // Test 6: wen=0 never pushes
    step();
    for (int i = 0; i < 50; i++) begin
      wen = 4'h0; pc = $urandom; wnum = 5'($urandom); wdata = $urandom;
      @(negedge clk);
      check("t6_no_valid", {31'd0, tx_valid}, 32'd0);
      check("t6_level", {27'd0, fifo_level}, 32'd0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
